// File: rtl/hazard_pkg.sv
// Shared constants, scoreboard entry type and Tnew helper for the hazard scheduler.
package hazard_pkg;

  localparam logic [1:0] FWD_GRF   = 2'd0;
  localparam logic [1:0] FWD_E     = 2'd1;
  localparam logic [1:0] FWD_M     = 2'd2;
  localparam logic [1:0] FWD_W     = 2'd3;
  localparam logic [1:0] TUSE_NONE = 2'd3;

  typedef struct packed {
    logic [4:0] dst;
    logic [1:0] tnew;
  } sb_entry_t;

  localparam sb_entry_t SB_EMPTY = '{dst: 5'd0, tnew: 2'd0};

  function automatic logic [1:0] sat_dec(input logic [1:0] x);
    return (x == 2'd0) ? 2'd0 : x - 2'd1;
  endfunction

endpackage

// File: rtl/md_busy_counter.sv
// Multiply/divide busy counter: loads on a start in E, counts down to idle.
module md_busy_counter #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic md_start_e,
  input  logic md_div_e,
  output logic md_busy
);

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  logic [3:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= 4'd0;
    end else if (md_start_e) begin
      r_cnt <= md_div_e ? DIV_LOAD : MULT_LOAD;
    end else if (r_cnt != 4'd0) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  assign md_busy = (r_cnt != 4'd0);

endmodule

// File: rtl/hazard_scheduler.sv
// Pipeline sequencer: shadow E/M/W scoreboard, D-stage stall/flush decisions and
// forwarding selects for the D and E operand muxes.
module hazard_scheduler
  import hazard_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rs_d,
  input  logic [4:0] rt_d,
  input  logic [1:0] tuse_rs_d,
  input  logic [1:0] tuse_rt_d,
  input  logic [4:0] dst_d,
  input  logic [1:0] tnew_d,
  input  logic       md_start_d,
  input  logic       md_div_d,
  input  logic       md_use_d,
  output logic       stall,
  output logic       flush_e,
  output logic [1:0] fwd_rs_d,
  output logic [1:0] fwd_rt_d,
  output logic [1:0] fwd_rs_e,
  output logic [1:0] fwd_rt_e,
  output logic       md_busy
);

  sb_entry_t  r_sb_e, r_sb_m, r_sb_w;
  logic [4:0] r_rs_e, r_rt_e;
  logic       r_md_start_e, r_md_div_e;
  logic       w_data_stall;

  // Only E and M can stall; a W producer is always ready (tnew already 0).
  function automatic logic data_stall(input logic [4:0] r, input logic [1:0] tuse,
                                      input sb_entry_t e, input sb_entry_t m);
    if (r == 5'd0 || tuse == TUSE_NONE) return 1'b0;
    if (e.dst == r) return e.tnew > tuse;
    if (m.dst == r) return m.tnew > tuse;
    return 1'b0;
  endfunction

  function automatic logic [1:0] fwd_sel_d(input logic [4:0] r, input sb_entry_t e,
                                           input sb_entry_t m, input sb_entry_t w);
    if (r == 5'd0) return FWD_GRF;
    if (e.dst == r) return (e.tnew == 2'd0) ? FWD_E : FWD_GRF;
    if (m.dst == r) return (m.tnew == 2'd0) ? FWD_M : FWD_GRF;
    if (w.dst == r) return (w.tnew == 2'd0) ? FWD_W : FWD_GRF;
    return FWD_GRF;
  endfunction

  function automatic logic [1:0] fwd_sel_e(input logic [4:0] r, input sb_entry_t m,
                                           input sb_entry_t w);
    if (r == 5'd0) return FWD_GRF;
    if (m.dst == r) return (m.tnew == 2'd0) ? FWD_M : FWD_GRF;
    if (w.dst == r) return (w.tnew == 2'd0) ? FWD_W : FWD_GRF;
    return FWD_GRF;
  endfunction

  always_comb begin
    w_data_stall = data_stall(rs_d, tuse_rs_d, r_sb_e, r_sb_m)
                 | data_stall(rt_d, tuse_rt_d, r_sb_e, r_sb_m);
    stall    = w_data_stall | (md_use_d & (md_busy | r_md_start_e));
    flush_e  = stall;
    fwd_rs_d = fwd_sel_d(rs_d, r_sb_e, r_sb_m, r_sb_w);
    fwd_rt_d = fwd_sel_d(rt_d, r_sb_e, r_sb_m, r_sb_w);
    fwd_rs_e = fwd_sel_e(r_rs_e, r_sb_m, r_sb_w);
    fwd_rt_e = fwd_sel_e(r_rt_e, r_sb_m, r_sb_w);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sb_e       <= SB_EMPTY;
      r_sb_m       <= SB_EMPTY;
      r_sb_w       <= SB_EMPTY;
      r_rs_e       <= 5'd0;
      r_rt_e       <= 5'd0;
      r_md_start_e <= 1'b0;
      r_md_div_e   <= 1'b0;
    end else begin
      r_sb_w <= '{dst: r_sb_m.dst, tnew: sat_dec(r_sb_m.tnew)};
      r_sb_m <= '{dst: r_sb_e.dst, tnew: sat_dec(r_sb_e.tnew)};
      if (stall) begin
        r_sb_e       <= SB_EMPTY;
        r_rs_e       <= 5'd0;
        r_rt_e       <= 5'd0;
        r_md_start_e <= 1'b0;
        r_md_div_e   <= 1'b0;
      end else begin
        r_sb_e       <= '{dst: dst_d, tnew: tnew_d};
        r_rs_e       <= rs_d;
        r_rt_e       <= rt_d;
        r_md_start_e <= md_start_d;
        r_md_div_e   <= md_start_d & md_div_d;
      end
    end
  end

  md_busy_counter #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_md_busy_counter (
    .clk       (clk),
    .reset     (reset),
    .md_start_e(r_md_start_e),
    .md_div_e  (r_md_div_e),
    .md_busy   (md_busy)
  );

endmodule

// File: tb/tb_hazard_scheduler.sv
// Directed and random checks of hazard_scheduler against an instruction-list pipeline model.
module tb_hazard_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs_d, rt_d, dst_d;
  logic [1:0] tuse_rs_d, tuse_rt_d, tnew_d;
  logic       md_start_d, md_div_d, md_use_d;
  logic       stall, flush_e, md_busy;
  logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;

  always #5 clk = ~clk;

  hazard_scheduler #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .rs_d      (rs_d),
    .rt_d      (rt_d),
    .tuse_rs_d (tuse_rs_d),
    .tuse_rt_d (tuse_rt_d),
    .dst_d     (dst_d),
    .tnew_d    (tnew_d),
    .md_start_d(md_start_d),
    .md_div_d  (md_div_d),
    .md_use_d  (md_use_d),
    .stall     (stall),
    .flush_e   (flush_e),
    .fwd_rs_d  (fwd_rs_d),
    .fwd_rt_d  (fwd_rt_d),
    .fwd_rs_e  (fwd_rs_e),
    .fwd_rt_e  (fwd_rt_e),
    .md_busy   (md_busy)
  );

  // Model: the instructions sitting in E, M, W (index 0..2) with the Tnew they had on entering E.
  typedef struct {
    int dst;
    int tnew0;
    int rs;
    int rt;
    bit md_start;
    bit md_div;
  } instr_t;

  instr_t pipe[3];
  int     cyc;
  int     last_start;
  int     last_n;
  int     checks = 0;
  int     errors = 0;

  logic       obs_stall, obs_busy;
  logic [1:0] obs_fwd_rs_d, obs_fwd_rs_e;

  function automatic instr_t bubble();
    instr_t b;
    b.dst = 0; b.tnew0 = 0; b.rs = 0; b.rt = 0; b.md_start = 0; b.md_div = 0;
    return b;
  endfunction

  function automatic int cur_tnew(int k);
    return (pipe[k].tnew0 > k) ? pipe[k].tnew0 - k : 0;
  endfunction

  // Youngest stage in [lo..2] writing register r, or -1.
  function automatic int nearest(int r, int lo);
    if (r == 0) return -1;
    for (int k = lo; k < 3; k++) if (pipe[k].dst == r) return k;
    return -1;
  endfunction

  function automatic bit m_data_stall(int r, int tuse);
    int k;
    k = nearest(r, 0);
    if (tuse == 3 || k < 0 || k == 2) return 0;
    return cur_tnew(k) > tuse;
  endfunction

  function automatic logic [1:0] m_fwd(int r, int lo);
    int k;
    k = nearest(r, lo);
    if (k < 0 || cur_tnew(k) != 0) return 2'd0;
    return 2'(k + 1);
  endfunction

  function automatic bit m_busy();
    return (cyc > last_start) && (cyc - last_start <= last_n);
  endfunction

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 3; k++) pipe[k] = bubble();
    last_start = -1000;
    last_n = 0;
  endtask

  // One clock: drive D, compare all outputs at negedge, advance model at posedge.
  task automatic step(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [1:0] trs, input logic [1:0] trt, input logic [4:0] dst,
                      input logic [1:0] tnew, input logic mds, input logic mdd,
                      input logic mdu);
    logic exp_stall;
    instr_t d;
    reset = rst; rs_d = rs; rt_d = rt; tuse_rs_d = trs; tuse_rt_d = trt;
    dst_d = dst; tnew_d = tnew; md_start_d = mds; md_div_d = mdd; md_use_d = mdu;
    @(negedge clk);
    exp_stall = m_data_stall(int'(rs), int'(trs)) || m_data_stall(int'(rt), int'(trt))
             || (mdu && (m_busy() || pipe[0].md_start));
    chk("stall",    {1'b0, stall},   {1'b0, exp_stall});
    chk("flush_e",  {1'b0, flush_e}, {1'b0, exp_stall});
    chk("md_busy",  {1'b0, md_busy}, {1'b0, m_busy()});
    chk("fwd_rs_d", fwd_rs_d, m_fwd(int'(rs), 0));
    chk("fwd_rt_d", fwd_rt_d, m_fwd(int'(rt), 0));
    chk("fwd_rs_e", fwd_rs_e, m_fwd(pipe[0].rs, 1));
    chk("fwd_rt_e", fwd_rt_e, m_fwd(pipe[0].rt, 1));
    obs_stall = stall; obs_busy = md_busy;
    obs_fwd_rs_d = fwd_rs_d; obs_fwd_rs_e = fwd_rs_e;
    @(posedge clk);
    if (rst) begin
      model_clear();
    end else begin
      if (pipe[0].md_start) begin
        last_start = cyc;
        last_n = pipe[0].md_div ? 10 : 5;
      end
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      if (exp_stall) begin
        pipe[0] = bubble();
      end else begin
        d.dst = int'(dst); d.tnew0 = int'(tnew); d.rs = int'(rs); d.rt = int'(rt);
        d.md_start = mds; d.md_div = mds & mdd;
        pipe[0] = d;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic nop();
    step(1'b0, 5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int nstall, nbusy;
    logic [4:0] r_rs, r_rt, r_dst;
    logic [1:0] r_trs, r_trt, r_tnew;
    logic r_mds, r_mdd, r_mdu, r_rst;

    cyc = 0;
    model_clear();
    reset = 1'b1; rs_d = '0; rt_d = '0; tuse_rs_d = 2'd3; tuse_rt_d = 2'd3;
    dst_d = '0; tnew_d = '0; md_start_d = 0; md_div_d = 0; md_use_d = 0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state with a reader presenting live registers.
    step(1'b0, 5'd8, 5'd9, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b1);
    chk("reset_stall", {1'b0, obs_stall}, 2'd0);
    chk("reset_busy",  {1'b0, obs_busy},  2'd0);

    // lw $8 ; addu $9,$8,$0
    step(1'b0, 5'd0, 5'd0, 2'd3, 2'd3, 5'd8, 2'd2, 1'b0, 1'b0, 1'b0);
    step(1'b0, 5'd8, 5'd0, 2'd1, 2'd3, 5'd9, 2'd1, 1'b0, 1'b0, 1'b0);
    chk("lw_use_stall", {1'b0, obs_stall}, 2'd1);
    step(1'b0, 5'd8, 5'd0, 2'd1, 2'd3, 5'd9, 2'd1, 1'b0, 1'b0, 1'b0);
    chk("lw_use_go", {1'b0, obs_stall}, 2'd0);
    nop();
    chk("lw_fwd_e_w", obs_fwd_rs_e, 2'd3);
    nop(); nop();

    // addu $8 ; beq $8
    step(1'b0, 5'd0, 5'd0, 2'd3, 2'd3, 5'd8, 2'd1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 5'd8, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    chk("beq_stall", {1'b0, obs_stall}, 2'd1);
    step(1'b0, 5'd8, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    chk("beq_go", {1'b0, obs_stall}, 2'd0);
    chk("beq_fwd_m", obs_fwd_rs_d, 2'd2);
    nop(); nop(); nop();

    // Two writers of $8 back to back: the younger one in E must win.
    step(1'b0, 5'd0, 5'd0, 2'd3, 2'd3, 5'd8, 2'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 5'd0, 5'd0, 2'd3, 2'd3, 5'd8, 2'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 5'd8, 5'd0, 2'd1, 2'd3, 5'd9, 2'd1, 1'b0, 1'b0, 1'b0);
    chk("e_beats_m", obs_fwd_rs_d, 2'd1);
    nop(); nop(); nop();

    // div ; mflo
    step(1'b0, 5'd8, 5'd9, 2'd1, 2'd1, 5'd0, 2'd0, 1'b1, 1'b1, 1'b1);
    nstall = 0; nbusy = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 5'd0, 5'd0, 2'd3, 2'd3, 5'd8, 2'd1, 1'b0, 1'b0, 1'b1);
      if (obs_busy) nbusy++;
      if (!obs_stall) break;
      nstall++;
    end
    chk("div_stalls", 2'(nstall == 11), 2'd1);
    chk("div_busy",   2'(nbusy == 10),  2'd1);
    nop(); nop(); nop();

    // Reset mid-divide.
    step(1'b0, 5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b1, 1'b1, 1'b1);
    nop(); nop(); nop();
    chk("div_mid_busy", {1'b0, obs_busy}, 2'd1);
    step(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 5'd8, 5'd0, 2'd0, 2'd3, 5'd8, 2'd1, 1'b0, 1'b0, 1'b1);
    chk("rst_div_busy",  {1'b0, obs_busy},  2'd0);
    chk("rst_div_stall", {1'b0, obs_stall}, 2'd0);
    nop(); nop(); nop();

    // Writer with dst=0 then a reader of $0.
    step(1'b0, 5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    chk("r0_stall", {1'b0, obs_stall}, 2'd0);
    chk("r0_fwd",   obs_fwd_rs_d, 2'd0);

    // Random traffic over a small register set; a stalled D instruction is re-presented.
    r_rs = 0; r_rt = 0; r_dst = 0; r_trs = 3; r_trt = 3; r_tnew = 0;
    r_mds = 0; r_mdd = 0; r_mdu = 0;
    for (int i = 0; i < 600; i++) begin
      if (i == 0 || !obs_stall) begin
        r_rs  = 5'($urandom_range(0, 3));
        r_rt  = 5'($urandom_range(0, 3));
        r_trs = 2'($urandom_range(0, 3));
        r_trt = 2'($urandom_range(0, 3));
        r_dst = 5'($urandom_range(0, 3));
        r_tnew = 2'($urandom_range(0, 2));
        r_mds = ($urandom_range(0, 15) == 0);
        r_mdd = 1'($urandom_range(0, 1));
        r_mdu = r_mds | ($urandom_range(0, 5) == 0);
      end
      r_rst = ($urandom_range(0, 99) == 0);
      step(r_rst, r_rs, r_rt, r_trs, r_trt, r_dst, r_tnew, r_mds, r_mdd, r_mdu);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
